ip_stream_assemble_pipe: RTL

//  TX-side counterpart of the RX IP stream formatter; sits between the TX IP header/payload producer and the MAC.

---
 rtl/ip_stream_assemble_pipe_if.sv | 41 ++++
 rtl/ip_stream_assemble_pipe.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ip_stream_assemble_pipe_if.sv
// ip_stream_assemble_pipe_if: header, payload and output stream signals of the IPv4 TX assembler
interface ip_stream_assemble_pipe_if #(
    parameter int DATA_WIDTH     = 256,
    parameter int PADBYTES_WIDTH = $clog2(DATA_WIDTH/8),
    parameter int HDR_WIDTH      = 160,
    parameter int TS_WIDTH       = 96
);
    logic                      src_ip_assemble_tx_hdr_val;
    logic                      ip_assemble_src_tx_hdr_rdy;
    logic [HDR_WIDTH-1:0]      src_ip_assemble_tx_ip_hdr;
    logic [TS_WIDTH-1:0]       src_ip_assemble_tx_timestamp;
    logic                      src_ip_assemble_tx_data_val;
    logic                      ip_assemble_src_tx_data_rdy;
    logic [DATA_WIDTH-1:0]     src_ip_assemble_tx_data;
    logic                      src_ip_assemble_tx_last;
    logic [PADBYTES_WIDTH-1:0] src_ip_assemble_tx_padbytes;
    logic                      ip_assemble_dst_tx_val;
    logic                      dst_ip_assemble_tx_rdy;
    logic [DATA_WIDTH-1:0]     ip_assemble_dst_tx_data;
    logic                      ip_assemble_dst_tx_last;
    logic [PADBYTES_WIDTH-1:0] ip_assemble_dst_tx_padbytes;
    logic [TS_WIDTH-1:0]       ip_assemble_dst_tx_timestamp;

    modport master (
        output src_ip_assemble_tx_hdr_val, src_ip_assemble_tx_ip_hdr, src_ip_assemble_tx_timestamp,
        output src_ip_assemble_tx_data_val, src_ip_assemble_tx_data, src_ip_assemble_tx_last,
        output src_ip_assemble_tx_padbytes, dst_ip_assemble_tx_rdy,
        input  ip_assemble_src_tx_hdr_rdy, ip_assemble_src_tx_data_rdy, ip_assemble_dst_tx_val,
        input  ip_assemble_dst_tx_data, ip_assemble_dst_tx_last, ip_assemble_dst_tx_padbytes,
        input  ip_assemble_dst_tx_timestamp
    );

    modport slave (
        input  src_ip_assemble_tx_hdr_val, src_ip_assemble_tx_ip_hdr, src_ip_assemble_tx_timestamp,
        input  src_ip_assemble_tx_data_val, src_ip_assemble_tx_data, src_ip_assemble_tx_last,
        input  src_ip_assemble_tx_padbytes, dst_ip_assemble_tx_rdy,
        output ip_assemble_src_tx_hdr_rdy, ip_assemble_src_tx_data_rdy, ip_assemble_dst_tx_val,
        output ip_assemble_dst_tx_data, ip_assemble_dst_tx_last, ip_assemble_dst_tx_padbytes,
        output ip_assemble_dst_tx_timestamp
    );
endinterface

// File: rtl/ip_stream_assemble_pipe.sv
// ip_stream_assemble_pipe: prepend a checksummed 20-byte IPv4 header to a TX payload stream
package ip_stream_assemble_pipe_pkg;
    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] total_length;
        logic [15:0] id;
        logic [2:0]  flags;
        logic [12:0] frag_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] chksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ip_pkt_hdr;
    typedef struct packed {
        logic [31:0] pkt_id;
        logic [63:0] tstamp;
    } tracker_stats_struct;
endpackage

module ip_stream_assemble_pipe
    import ip_stream_assemble_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input logic                      clk,
    input logic                      rst_n,
    ip_stream_assemble_pipe_if.slave bus
);
    localparam int DATA_BYTES     = DATA_WIDTH/8;
    localparam int PADBYTES_WIDTH = $clog2(DATA_BYTES);
    localparam int HB             = 20;
    localparam int HW             = 8*HB;
    typedef logic [PADBYTES_WIDTH-1:0] pad_t;
    typedef enum logic [2:0] {IDLE, CSUM, FIRST, PAYLOAD, TAIL} state_t;

    state_t              state, state_nxt;
    logic                live;
    ip_pkt_hdr           hdr_q;
    tracker_stats_struct ts_q;
    logic [HW-1:0]       carry, lead;
    pad_t                pad_q, pad_in, emit_pad, out_pad;
    logic                out_val, out_last;
    logic [DATA_WIDTH-1:0] out_data, raw, emit_data;
    tracker_stats_struct out_ts;
    logic                load, hdr_rdy, data_rdy, hdr_hs, data_hs, ends_now, emit, emit_last;
    logic [31:0]         sum;
    logic [16:0]         fold1;
    logic [15:0]         fold2, chk;

    // ones-complement header checksum with the checksum word treated as zero
    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++)
            sum = sum + ((i == 5) ? 32'h0 : 32'(hdr_q[HW-1-16*i -: 16]));
        fold1 = 17'(sum[15:0]) + 17'(sum[31:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);
        chk   = ~fold2;
    end

    // handshakes, beat formatting and next-state selection
    always_comb begin
        load      = !out_val || bus.dst_ip_assemble_tx_rdy;
        hdr_rdy   = live && state == IDLE;
        data_rdy  = (state == FIRST || state == PAYLOAD) && load;
        hdr_hs    = hdr_rdy && bus.src_ip_assemble_tx_hdr_val;
        data_hs   = data_rdy && bus.src_ip_assemble_tx_data_val;
        pad_in    = bus.src_ip_assemble_tx_padbytes;
        ends_now  = bus.src_ip_assemble_tx_last && pad_in >= pad_t'(HB);
        emit      = data_hs || (state == TAIL && load);
        emit_last = state == TAIL || ends_now;
        emit_pad  = state == TAIL ? pad_t'(DATA_BYTES-HB) + pad_q : ends_now ? pad_in - pad_t'(HB) : '0;
        lead      = state == FIRST ? hdr_q : carry;
        raw       = state == TAIL ? {carry, {(DATA_WIDTH-HW){1'b0}}}
                                  : {lead, bus.src_ip_assemble_tx_data[DATA_WIDTH-1 -: DATA_WIDTH-HW]};
        emit_data = raw & ({DATA_WIDTH{1'b1}} << (8*emit_pad));
        state_nxt = state;
        unique case (state)
            IDLE:          state_nxt = hdr_hs ? CSUM : IDLE;
            CSUM:          state_nxt = FIRST;
            FIRST, PAYLOAD: state_nxt = !data_hs ? state : !bus.src_ip_assemble_tx_last ? PAYLOAD
                                                 : ends_now ? IDLE : TAIL;
            TAIL:          state_nxt = load ? IDLE : TAIL;
            default:       state_nxt = IDLE;
        endcase
    end

    // state register; live holds header ready low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    // latched header/timestamp and the 20 bytes carried into the next beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q <= '0;
            ts_q  <= '0;
            carry <= '0;
            pad_q <= '0;
        end else begin
            if (hdr_hs) begin
                hdr_q <= bus.src_ip_assemble_tx_ip_hdr;
                ts_q  <= bus.src_ip_assemble_tx_timestamp;
            end
            if (state == CSUM) hdr_q.chksum <= chk;
            if (data_hs) begin
                carry <= bus.src_ip_assemble_tx_data[HW-1:0];
                pad_q <= pad_in;
            end
        end
    end

    // single output register, held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_pad  <= '0;
            out_ts   <= '0;
        end else if (load) begin
            out_val <= emit;
            if (emit) begin
                out_data <= emit_data;
                out_last <= emit_last;
                out_pad  <= emit_pad;
                out_ts   <= ts_q;
            end
        end
    end

    assign bus.ip_assemble_src_tx_hdr_rdy   = hdr_rdy;
    assign bus.ip_assemble_src_tx_data_rdy  = data_rdy;
    assign bus.ip_assemble_dst_tx_val       = out_val;
    assign bus.ip_assemble_dst_tx_data      = out_data;
    assign bus.ip_assemble_dst_tx_last      = out_last;
    assign bus.ip_assemble_dst_tx_padbytes  = out_pad;
    assign bus.ip_assemble_dst_tx_timestamp = out_ts;
endmodule
